// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             divByZero;

  modport master (
    output start, op, operandA, operandB,
    input  busy, done, hi, lo, divByZero
  );

  modport slave (
    input  start, op, operandA, operandB,
    output busy, done, hi, lo, divByZero
  );
endinterface

// File: rtl/md_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   part_rem;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum      = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    part_rem = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    // A set top bit means the partial remainder already exceeds any divisor.
    ge       = part_rem[WIDTH] | (part_rem[WIDTH-1:0] >= operand);
    diff     = part_rem[WIDTH-1:0] - operand;
    if (is_div)
      acc_out = {(ge ? diff : part_rem[WIDTH-1:0]), acc_in[WIDTH-2:0], ge};
    else
      acc_out = {sum, acc_in[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit producing HI/LO, one result bit per cycle.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  mult_div_unit_if.slave bus
);

  state_e state, state_nx;
  logic   accept, busy_c, done_c;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0]   opnd, a_raw;
  logic               is_div, neg_lo, neg_hi, b_zero;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dbz_q;

  op_e              op_in;
  logic             div_in, sa_in, sb_in;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      S_IDLE: if (bus.start) begin
        accept   = 1'b1;
        state_nx = S_CALC;
      end
      S_CALC: begin
        busy_c = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nx = S_FIXUP;
      end
      S_FIXUP: begin
        busy_c   = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = S_CALC;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    op_in  = op_e'(bus.op);
    div_in = op_is_div(op_in);
    sa_in  = op_is_signed(op_in) & bus.operandA[WIDTH-1];
    sb_in  = op_is_signed(op_in) & bus.operandB[WIDTH-1];
    mag_a  = sa_in ? (~bus.operandA + 1'b1) : bus.operandA;
    mag_b  = sb_in ? (~bus.operandB + 1'b1) : bus.operandB;
  end

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_in  (acc),
    .operand (opnd),
    .acc_out (acc_step)
  );

  // Signs are stripped at launch and reapplied here; the datapath only sees magnitudes.
  always_comb begin
    prod   = neg_lo ? (~acc + 1'b1) : acc;
    quo    = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem    = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_hi = b_zero ? a_raw : rem;
      res_lo = b_zero ? '1    : quo;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      b_zero <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dbz_q  <= 1'b0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        is_div <= div_in;
        neg_lo <= sa_in ^ sb_in;
        neg_hi <= div_in ? sa_in : (sa_in ^ sb_in);
        b_zero <= (bus.operandB == '0);
        a_raw  <= bus.operandA;
        acc    <= {{WIDTH{1'b0}}, (div_in ? mag_a : mag_b)};
        opnd   <= div_in ? mag_b : mag_a;
      end else if (state == S_CALC) begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
      end
      if (state == S_FIXUP) begin
        hi_q  <= res_hi;
        lo_q  <= res_lo;
        dbz_q <= is_div & b_zero;
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.divByZero = dbz_q;

endmodule
